// File: rtl/usb_cmd_parser_if.sv
// rtl/usb_cmd_parser_if.sv - FIFO read port plus register-write and status bus of the command parser
interface usb_cmd_parser_if;
  logic        fifo_empty;
  logic [7:0]  fifo_data;
  logic        fifo_rd_en;
  logic        reg_wr_en;
  logic [7:0]  reg_addr;
  logic [7:0]  reg_wr_data;
  logic        frame_ok;
  logic        frame_err;
  logic [1:0]  err_code;
  logic [15:0] frame_cnt;

  modport master (
    input  fifo_empty, fifo_data,
    output fifo_rd_en, reg_wr_en, reg_addr, reg_wr_data,
    output frame_ok, frame_err, err_code, frame_cnt
  );

  modport slave (
    output fifo_empty, fifo_data,
    input  fifo_rd_en, reg_wr_en, reg_addr, reg_wr_data,
    input  frame_ok, frame_err, err_code, frame_cnt
  );
endinterface

// File: rtl/usb_cmd_parser.sv
// rtl/usb_cmd_parser.sv - parses 55 AA ADDR LEN payload CHK frames from a byte FIFO into register writes
module usb_cmd_parser #(
  parameter int MAX_LEN     = 16,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic             clk,
  input  logic             reset_n,
  usb_cmd_parser_if.master bus
);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [2:0] {HDR0, HDR1, ADDR, LEN, DATA, CHK, EMIT} state_t;

  state_t        state, state_nxt;
  logic          pending, byte_vld, rd_en;
  logic [7:0]    addr_q, len_q, chk_q, idx;
  logic [7:0]    addr_hold, data_hold, wr_addr, wr_data;
  logic [TW-1:0] tcnt;
  logic          in_frame, timeout, last_wr;
  logic          err_pulse, frame_err_q;
  logic [1:0]    err_nxt, err_code_q;
  logic [15:0]   frame_cnt_q;
  logic [7:0]    buffer [MAX_LEN];

  // Non-FWFT FIFO: data arrives the cycle after the pop, so keep one read in flight at most.
  assign byte_vld = pending;
  assign rd_en    = reset_n && !bus.fifo_empty && !pending && (state != EMIT);

  assign in_frame = (state != HDR0) && (state != EMIT);
  assign timeout  = in_frame && !byte_vld && (tcnt == TW'(TIMEOUT_CYC - 1));
  assign last_wr  = (state == EMIT) && (idx == len_q - 8'd1);
  assign wr_addr  = addr_q + idx;
  assign wr_data  = buffer[idx[AW-1:0]];

  always_comb begin
    state_nxt = state;
    err_pulse = 1'b0;
    err_nxt   = 2'd0;
    if (timeout) begin
      state_nxt = HDR0;
      err_pulse = 1'b1;
      err_nxt   = 2'd3;
    end else begin
      case (state)
        HDR0: if (byte_vld && bus.fifo_data == 8'h55) state_nxt = HDR1;
        HDR1: if (byte_vld) begin
          if (bus.fifo_data == 8'hAA)      state_nxt = ADDR;
          else if (bus.fifo_data != 8'h55) state_nxt = HDR0;
        end
        ADDR: if (byte_vld) state_nxt = LEN;
        LEN:  if (byte_vld) begin
          if (bus.fifo_data == 8'h00 || {1'b0, bus.fifo_data} > 9'(MAX_LEN)) begin
            state_nxt = HDR0;
            err_pulse = 1'b1;
            err_nxt   = 2'd1;
          end else begin
            state_nxt = DATA;
          end
        end
        DATA: if (byte_vld && idx == len_q - 8'd1) state_nxt = CHK;
        CHK:  if (byte_vld) begin
          if (bus.fifo_data == chk_q) begin
            state_nxt = EMIT;
          end else begin
            state_nxt = HDR0;
            err_pulse = 1'b1;
            err_nxt   = 2'd2;
          end
        end
        EMIT: if (last_wr) state_nxt = HDR0;
        default: state_nxt = HDR0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= HDR0;
      pending     <= 1'b0;
      tcnt        <= '0;
      idx         <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      chk_q       <= '0;
      addr_hold   <= '0;
      data_hold   <= '0;
      frame_err_q <= 1'b0;
      err_code_q  <= '0;
      frame_cnt_q <= '0;
    end else begin
      state       <= state_nxt;
      pending     <= rd_en;
      frame_err_q <= err_pulse;
      if (err_pulse) err_code_q <= err_nxt;

      if (byte_vld || state_nxt == HDR0 || state_nxt == EMIT) tcnt <= '0;
      else                                                    tcnt <= tcnt + TW'(1);

      case (state)
        ADDR: if (byte_vld) begin
          addr_q <= bus.fifo_data;
          chk_q  <= bus.fifo_data;
        end
        LEN: if (byte_vld && state_nxt == DATA) begin
          len_q <= bus.fifo_data;
          chk_q <= chk_q + bus.fifo_data;
          idx   <= '0;
        end
        DATA: if (byte_vld) begin
          chk_q <= chk_q + bus.fifo_data;
          idx   <= idx + 8'd1;
        end
        CHK: if (byte_vld) idx <= '0;
        EMIT: begin
          idx       <= idx + 8'd1;
          addr_hold <= wr_addr;
          data_hold <= wr_data;
          if (last_wr) frame_cnt_q <= frame_cnt_q + 16'd1;
        end
        default: ;
      endcase
    end
  end

  // Payload buffer carries no reset; a frame is only emitted after it has been fully rewritten.
  always_ff @(posedge clk) begin
    if (state == DATA && byte_vld) buffer[idx[AW-1:0]] <= bus.fifo_data;
  end

  assign bus.fifo_rd_en  = rd_en;
  assign bus.reg_wr_en   = (state == EMIT);
  assign bus.reg_addr    = (state == EMIT) ? wr_addr : addr_hold;
  assign bus.reg_wr_data = (state == EMIT) ? wr_data : data_hold;
  assign bus.frame_ok    = last_wr;
  assign bus.frame_err   = frame_err_q;
  assign bus.err_code    = err_code_q;
  assign bus.frame_cnt   = frame_cnt_q;
endmodule

// File: tb/tb_usb_cmd_parser.sv
// tb/tb_usb_cmd_parser.sv - directed frame vectors plus timeout and reset sequences for usb_cmd_parser
module tb_usb_cmd_parser;
  localparam int MAX_LEN     = 16;
  localparam int TIMEOUT_CYC = 20;

  typedef struct {
    string          name;
    int             n;
    logic [191:0]   bytes;
    int             nwr;
    logic [255:0]   wr;
    int             ok;
    int             err;
    logic [1:0]     code;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  usb_cmd_parser_if bus();

  usb_cmd_parser #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;
  logic [7:0] stream[$];
  int rptr = 0;
  int cyc = 0;
  logic [15:0] wr_log[$];
  int wr_cyc[$];
  int ok_n = 0, err_n = 0, ok_cyc = 0, err_cyc = 0, last_pop_cyc = 0, b2b = 0;
  logic [1:0] last_code = 2'd0;
  logic prev_rd = 1'b0;

  // Non-FWFT FIFO model: pop on a sampled rd_en, data appears just after the edge.
  initial begin
    logic popped;
    bus.fifo_empty = 1'b1;
    bus.fifo_data  = 8'h00;
    forever begin
      @(negedge clk);
      popped = bus.fifo_rd_en;
      @(posedge clk);
      #1;
      if (popped && rptr < stream.size()) begin
        bus.fifo_data = stream[rptr];
        rptr++;
      end
      bus.fifo_empty = (rptr >= stream.size());
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.reg_wr_en) begin
      wr_log.push_back({bus.reg_addr, bus.reg_wr_data});
      wr_cyc.push_back(cyc);
    end
    if (bus.frame_ok) begin ok_n++; ok_cyc = cyc; end
    if (bus.frame_err) begin err_n++; last_code = bus.err_code; err_cyc = cyc; end
    if (bus.fifo_rd_en) begin
      if (prev_rd) b2b++;
      last_pop_cyc = cyc;
    end
    prev_rd = bus.fifo_rd_en;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic vec_t mk(input string nm, input int n, input logic [191:0] b, input int nwr,
                              input logic [255:0] w, input int ok, input int err, input logic [1:0] code);
    vec_t v;
    v.name = nm; v.n = n; v.bytes = b; v.nwr = nwr; v.wr = w;
    v.ok = ok; v.err = err; v.code = code;
    return v;
  endfunction

  task automatic drain(input string nm, input int budget);
    int t = 0;
    while (rptr < stream.size() && t < budget) begin
      @(posedge clk);
      t++;
    end
    check({nm, "_drain"}, 32'(rptr < stream.size()), 32'd0);
  endtask

  task automatic push_bytes(input logic [191:0] b, input int n);
    for (int i = 0; i < n; i++) stream.push_back(b[8*(n-1-i) +: 8]);
  endtask

  task automatic apply_vec(input vec_t v);
    int wb, okb, errb, nw;
    wb = wr_log.size(); okb = ok_n; errb = err_n;
    push_bytes(v.bytes, v.n);
    drain(v.name, 2*v.n + 40);
    repeat (MAX_LEN + 8) @(posedge clk);
    #2;
    nw = wr_log.size() - wb;
    check({v.name, "_nwr"}, 32'(nw), 32'(v.nwr));
    for (int i = 0; i < v.nwr && i < nw; i++) begin
      check($sformatf("%s_wr%0d", v.name, i), 32'(wr_log[wb+i]), 32'(v.wr[16*(v.nwr-1-i) +: 16]));
      check($sformatf("%s_wrcyc%0d", v.name, i), 32'(wr_cyc[wb+i] - wr_cyc[wb]), 32'(i));
    end
    check({v.name, "_ok"}, 32'(ok_n - okb), 32'(v.ok));
    check({v.name, "_err"}, 32'(err_n - errb), 32'(v.err));
    if (v.err != 0) check({v.name, "_code"}, 32'(last_code), 32'(v.code));
    if (v.ok != 0 && nw > 0) check({v.name, "_ok_last_wr"}, 32'(ok_cyc), 32'(wr_cyc[wb+nw-1]));
    exp_cnt += v.ok;
    check({v.name, "_cnt"}, 32'(bus.frame_cnt), 32'(exp_cnt));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vec_t vt[9];
    logic [191:0] b;
    logic [255:0] w;
    int wb, okb, errb, lat, t, wl;

    vt[0] = mk("basic",      7, 192'h55AA1002A1B265,   2, 256'h10A1_11B2, 1, 0, 2'd0);
    vt[1] = mk("addr_wrap",  7, 192'h55AAFF02010204,   2, 256'hFF01_0002, 1, 0, 2'd0);
    vt[2] = mk("bad_chk",    7, 192'h55AA1002A1B266,   0, 256'h0,         0, 1, 2'd2);
    vt[3] = mk("after_bad",  7, 192'h55AA1002A1B265,   2, 256'h10A1_11B2, 1, 0, 2'd0);
    vt[4] = mk("len_zero",   4, 192'h55AA1000,         0, 256'h0,         0, 1, 2'd1);
    vt[5] = mk("len_over",   4, 192'h55AA1011,         0, 256'h0,         0, 1, 2'd1);
    vt[6] = mk("resync",     8, 192'h335555AA20017E9F, 1, 256'h207E,      1, 0, 2'd0);
    vt[7] = mk("hdr1_other", 8, 192'h551255AA05013339, 1, 256'h0533,      1, 0, 2'd0);
    b = 192'h55AA0010;
    w = '0;
    for (int i = 0; i < 16; i++) begin
      b = (b << 8) | 192'(i);
      w = (w << 16) | 256'({8'(i), 8'(i)});
    end
    b = (b << 8) | 192'h88;
    vt[8] = mk("len_max", 21, b, 16, w, 1, 0, 2'd0);

    stream.push_back(8'h33);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rd_en",     32'(bus.fifo_rd_en), 32'd0);
    check("rst_wr_en",     32'(bus.reg_wr_en), 32'd0);
    check("rst_frame_ok",  32'(bus.frame_ok), 32'd0);
    check("rst_frame_err", 32'(bus.frame_err), 32'd0);
    check("rst_reg_addr",  32'(bus.reg_addr), 32'd0);
    check("rst_reg_data",  32'(bus.reg_wr_data), 32'd0);
    check("rst_err_code",  32'(bus.err_code), 32'd0);
    check("rst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
    @(posedge clk);
    #3 reset_n = 1'b1;
    drain("rst_junk", 20);
    repeat (4) @(posedge clk);
    check("rst_junk_silent", 32'(ok_n + err_n + wr_log.size()), 32'd0);

    foreach (vt[k]) apply_vec(vt[k]);

    // Header, address, then silence until the inter-byte timeout fires.
    errb = err_n; wb = wr_log.size();
    push_bytes(192'h55AA10, 3);
    drain("timeout", 40);
    t = 0;
    while (err_n == errb && t < 100) begin
      @(posedge clk);
      t++;
    end
    #2;
    check("timeout_pulse", 32'(err_n - errb), 32'd1);
    check("timeout_code", 32'(last_code), 32'd3);
    lat = err_cyc - last_pop_cyc;
    check("timeout_latency", 32'(lat >= TIMEOUT_CYC && lat <= TIMEOUT_CYC + 4), 32'd1);
    check("timeout_nwr", 32'(wr_log.size() - wb), 32'd0);
    apply_vec(vt[0]);

    // Reset asserted during the register-write burst of a full-length frame.
    wb = wr_log.size(); okb = ok_n; errb = err_n;
    push_bytes(vt[8].bytes, vt[8].n);
    t = 0;
    while (wr_log.size() == wb && t < 200) begin
      @(posedge clk);
      t++;
    end
    #3 reset_n = 1'b0;
    #1;
    wl = wr_log.size();
    check("midemit_wr_en", 32'(bus.reg_wr_en), 32'd0);
    check("midemit_cnt", 32'(bus.frame_cnt), 32'd0);
    check("midemit_partial", 32'(wl - wb > 0 && wl - wb < 16), 32'd1);
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #2;
    check("midemit_no_more_wr", 32'(wr_log.size()), 32'(wl));
    check("midemit_no_pulse", 32'((ok_n - okb) + (err_n - errb)), 32'd0);
    exp_cnt = 0;
    apply_vec(vt[1]);

    check("rd_back_to_back", 32'(b2b), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/usb_cmd_parser.md
USB_CMD_PARSER -- requirements
Module: usb_cmd_parser

Interface
REQ-001 Parameter MAX_LEN, default 16, maximum payload bytes per frame (1..256).
REQ-002 Parameter TIMEOUT_CYC, default 1_000_000, idle clk cycles allowed between bytes inside a frame.
REQ-003 clk  in  1  system clock; all logic on its rising edge; one clock domain only.
REQ-004 reset_n  in  1  asynchronous active-low reset.
REQ-005 fifo_empty  in  1  host-to-FPGA byte FIFO empty flag (read side of the USB bridge, clk domain).
REQ-006 fifo_data  in  8  FIFO read data, valid the cycle after fifo_rd_en (non-FWFT).
REQ-007 fifo_rd_en  out  1  FIFO pop strobe.
REQ-008 reg_wr_en  out  1  register-write strobe, one write per cycle.
REQ-009 reg_addr  out  8  register address for the current write.
REQ-010 reg_wr_data  out  8  register data for the current write.
REQ-011 frame_ok  out  1  one-cycle pulse, frame accepted.
REQ-012 frame_err  out  1  one-cycle pulse, frame rejected.
REQ-013 err_code  out  2  cause of the last rejection: 1 bad LEN, 2 checksum, 3 timeout; holds until the next frame_err.
REQ-014 frame_cnt  out  16  count of accepted frames, wraps FFFF->0000.

Function
REQ-015 Frame format: 0x55, 0xAA, ADDR, LEN, LEN payload bytes, CHK; CHK = (ADDR + LEN + sum of payload) mod 256.
REQ-016 pending register = fifo_rd_en delayed one cycle; byte_vld = pending; byte = fifo_data in that cycle.
REQ-017 fifo_rd_en = !fifo_empty && !pending && state != EMIT, giving at most one outstanding read and at most one byte per 2 cycles.
REQ-018 States: HDR0, HDR1, ADDR, LEN, DATA, CHK, EMIT; transitions occur only on byte_vld except in EMIT and on timeout.
REQ-019 HDR0: 0x55 -> HDR1; any other byte is discarded silently.
REQ-020 HDR1: 0xAA -> ADDR; 0x55 -> stay in HDR1; other -> HDR0, no error.
REQ-021 ADDR: latch ADDR, seed checksum with ADDR -> LEN.
REQ-022 LEN: 0 or > MAX_LEN -> frame_err, err_code=1, HDR0; otherwise latch LEN, add it to checksum, clear index -> DATA.
REQ-023 DATA: write the byte into the internal MAX_LEN x 8 buffer at index, add it to checksum, increment index; after the LEN-th byte -> CHK.
REQ-024 CHK: byte equal to checksum -> EMIT with index cleared; mismatch -> frame_err, err_code=2, HDR0, no writes.
REQ-025 EMIT: LEN consecutive cycles with reg_wr_en=1, reg_addr=(ADDR+i) mod 256, reg_wr_data=buf[i], i=0..LEN-1.
REQ-026 The first write occurs in the cycle after the CHK byte_vld cycle.
REQ-027 frame_ok pulses and frame_cnt increments in the cycle of the last write; next state HDR0.
REQ-028 Timeout counter clears on every byte_vld and on entry to HDR0; it counts in HDR1..CHK while no byte arrives.
REQ-029 When the counter reaches TIMEOUT_CYC-1: frame_err, err_code=3, HDR0; the buffer is discarded.
REQ-030 If a read is pending at timeout, the arriving byte is processed in HDR0.
REQ-031 Outside the defined pulses, reg_wr_en, frame_ok and frame_err are 0; reg_addr and reg_wr_data hold their last value.
REQ-032 Checksum and address arithmetic are 8-bit and wrap modulo 256.

Reset
REQ-033 During reset_n=0: state=HDR0; pending, fifo_rd_en, reg_wr_en, frame_ok, frame_err = 0; reg_addr, reg_wr_data, err_code, frame_cnt, timeout counter and index = 0. Buffer contents are not reset.
REQ-034 Reset mid-frame or mid-EMIT aborts immediately: no further writes and no pulses.
REQ-035 After release, the first fifo_rd_en occurs no earlier than the first rising edge with reset_n=1 and fifo_empty=0.

Verification
REQ-036 Bytes 55 AA 10 02 A1 B2 65 -> writes (10,A1) then (11,B2) on consecutive cycles; frame_ok with the 2nd write; frame_cnt=1.
REQ-037 Bytes 55 AA FF 02 01 02 04 -> writes (FF,01), (00,02), showing address wrap; frame_ok.
REQ-038 Bytes 55 AA 10 02 A1 B2 66 -> frame_err, err_code=2, zero writes; a following valid frame is accepted.
REQ-039 Bytes 55 AA 10 00, then separately LEN=MAX_LEN+1 -> frame_err, err_code=1 each time, no writes.
REQ-040 Bytes 55 AA 10, then FIFO empty for TIMEOUT_CYC cycles -> frame_err, err_code=3; resync on the next 55 AA.
REQ-041 Bytes 33 55 55 AA 20 01 7E 9F -> write (20,7E); frame_ok; fifo_rd_en is never asserted on two consecutive cycles.
